mmio_bus_decoder: RTL and testbench

- Parametrised, registered memory-map decoder between the ARMv4 core's data port and N memory-mapped targets (data memory, mouse, sprite memory, ...).
- Decodes the address against a base/mask table and drives a one-hot target select.
- Runs a request/ack handshake with the selected target and returns read data to the core.
- Flags an error for unmapped addresses and, optionally, for target timeout.

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_addr_match.sv | 34 +++
 rtl/mmio_bus_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_mmio_bus_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO bus decoder.
//   - mmio_state_e : decoder FSM states
//   - *_BASE/*_MASK: default target map (data memory, mouse, sprite memory)
//   - region_hit() : base/mask region membership test
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mmio_state_e;

    // Widest address the region test handles; narrower buses are zero-extended.
    localparam int unsigned MAP_AW = 64;

    localparam logic [31:0] DMEM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DMEM_MASK   = 32'h0000_003F;
    localparam logic [31:0] MOUSE_BASE  = 32'h0000_0040;
    localparam logic [31:0] MOUSE_MASK  = 32'h0000_0000;
    localparam logic [31:0] SPRITE_BASE = 32'h0000_1000;
    localparam logic [31:0] SPRITE_MASK = 32'h0000_0FFF;

    // An address hits when all bits outside the offset mask equal the base.
    function automatic logic region_hit(input logic [MAP_AW-1:0] addr,
                                        input logic [MAP_AW-1:0] base,
                                        input logic [MAP_AW-1:0] mask);
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// Combinational priority matcher of an address against a base/mask table.
// Ports:
//   addr : address to decode
//   hit  : 1 when any region matches
//   idx  : index of the matching region; lowest index wins on overlap
module mmio_addr_match
    import mmio_pkg::*;
#(
    parameter int unsigned          NDEV        = 3,
    parameter int unsigned          AW          = 32,
    parameter int unsigned          IW          = (NDEV > 1) ? $clog2(NDEV) : 1,
    parameter logic [NDEV*AW-1:0]   REGION_BASE = {SPRITE_BASE, MOUSE_BASE, DMEM_BASE},
    parameter logic [NDEV*AW-1:0]   REGION_MASK = {SPRITE_MASK, MOUSE_MASK, DMEM_MASK}
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan from the highest index down so the lowest matching region is kept last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NDEV) - 1; i >= 0; i--) begin
            if (region_hit(MAP_AW'(addr),
                           MAP_AW'(REGION_BASE[i*AW +: AW]),
                           MAP_AW'(REGION_MASK[i*AW +: AW]))) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_bus_decoder.sv
// Registered memory-map decoder between the core data port and NDEV targets.
// Accepts a request in IDLE, selects the matching target one-hot, waits for its
// ack, then returns data/error to the core with a one-cycle cpu_ready pulse.
// Optional build macro MMIO_TIMEOUT_EN: abort an access with cpu_err when the
// selected target does not ack within TIMEOUT cycles.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata: core request (req sampled only in IDLE)
//   cpu_rdata/ready/err  : completion pulse with read data and error flag
//   dev_sel/we/addr/wdata: one-hot target select and registered request
//   dev_rdata, dev_ack   : per-target read data and completion
module mmio_bus_decoder
    import mmio_pkg::*;
#(
    parameter int unsigned        NDEV        = 3,
    parameter int unsigned        AW          = 32,
    parameter int unsigned        DW          = 32,
    parameter logic [NDEV*AW-1:0] REGION_BASE = {SPRITE_BASE, MOUSE_BASE, DMEM_BASE},
    parameter logic [NDEV*AW-1:0] REGION_MASK = {SPRITE_MASK, MOUSE_MASK, DMEM_MASK},
    parameter int unsigned        TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [AW-1:0]      cpu_addr,
    input  logic [DW-1:0]      cpu_wdata,
    output logic [DW-1:0]      cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_err,
    output logic [NDEV-1:0]    dev_sel,
    output logic               dev_we,
    output logic [AW-1:0]      dev_addr,
    output logic [DW-1:0]      dev_wdata,
    input  logic [NDEV*DW-1:0] dev_rdata,
    input  logic [NDEV-1:0]    dev_ack
);

    localparam int unsigned IW = (NDEV > 1) ? $clog2(NDEV) : 1;

    mmio_state_e     state;
    mmio_state_e     state_nxt;

    logic            match_hit_c;
    logic [IW-1:0]   match_idx_c;
    logic [AW-1:0]   match_mask_c;

    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_nxt;
    logic            sel_ack_c;
    logic [DW-1:0]   sel_rdata_c;
    logic            timeout_c;

    logic [DW-1:0]   cpu_rdata_nxt;
    logic            cpu_ready_nxt;
    logic            cpu_err_nxt;
    logic [NDEV-1:0] dev_sel_nxt;
    logic            dev_we_nxt;
    logic [AW-1:0]   dev_addr_nxt;
    logic [DW-1:0]   dev_wdata_nxt;

    mmio_addr_match #(
        .NDEV        (NDEV),
        .AW          (AW),
        .IW          (IW),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_match (
        .addr (cpu_addr),
        .hit  (match_hit_c),
        .idx  (match_idx_c)
    );

    // Offset mask of the region currently being decoded.
    always_comb begin
        match_mask_c = '0;
        for (int i = 0; i < int'(NDEV); i++) begin
            if (IW'(i) == match_idx_c) begin
                match_mask_c = REGION_MASK[i*AW +: AW];
            end
        end
    end

    // Ack and read data of the latched target; other targets are ignored.
    always_comb begin
        sel_ack_c   = 1'b0;
        sel_rdata_c = '0;
        for (int i = 0; i < int'(NDEV); i++) begin
            if (IW'(i) == idx_q) begin
                sel_ack_c   = dev_ack[i];
                sel_rdata_c = dev_rdata[i*DW +: DW];
            end
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] to_cnt;

    // Counts ACCESS cycles without the selected ack; cleared whenever not in ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != ACCESS) begin
            to_cnt <= '0;
        end else if (!sel_ack_c) begin
            to_cnt <= to_cnt + CW'(1);
        end
    end

    // An ack in the final cycle wins over the timeout.
    assign timeout_c = (state == ACCESS) && !sel_ack_c && (to_cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout_c;

    assign timeout_c        = 1'b0;
    assign unused_timeout_c = ^32'(TIMEOUT);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nxt = match_hit_c ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (sel_ack_c || timeout_c) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        idx_nxt       = idx_q;
        cpu_rdata_nxt = '0;
        cpu_ready_nxt = 1'b0;
        cpu_err_nxt   = 1'b0;
        dev_sel_nxt   = '0;
        dev_we_nxt    = 1'b0;
        dev_addr_nxt  = '0;
        dev_wdata_nxt = '0;
        case (state)
            IDLE: begin
                if (cpu_req && match_hit_c) begin
                    idx_nxt       = match_idx_c;
                    dev_we_nxt    = cpu_we;
                    dev_addr_nxt  = cpu_addr & match_mask_c;
                    dev_wdata_nxt = cpu_wdata;
                    for (int i = 0; i < int'(NDEV); i++) begin
                        dev_sel_nxt[i] = (IW'(i) == match_idx_c);
                    end
                end else if (cpu_req) begin
                    cpu_ready_nxt = 1'b1;
                    cpu_err_nxt   = 1'b1;
                end
            end
            ACCESS: begin
                if (sel_ack_c) begin
                    cpu_ready_nxt = 1'b1;
                    cpu_rdata_nxt = dev_we ? '0 : sel_rdata_c;
                end else if (timeout_c) begin
                    cpu_ready_nxt = 1'b1;
                    cpu_err_nxt   = 1'b1;
                end else begin
                    dev_sel_nxt   = dev_sel;
                    dev_we_nxt    = dev_we;
                    dev_addr_nxt  = dev_addr;
                    dev_wdata_nxt = dev_wdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Output and transaction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
        end else begin
            idx_q     <= idx_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            cpu_ready <= cpu_ready_nxt;
            cpu_err   <= cpu_err_nxt;
            dev_sel   <= dev_sel_nxt;
            dev_we    <= dev_we_nxt;
            dev_addr  <= dev_addr_nxt;
            dev_wdata <= dev_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Self-checking bench for mmio_bus_decoder: a cycle-indexed expectation table
// built from the address map and each transaction's ack timing, compared
// against the DUT every cycle, plus literal checks of key transactions.
module tb_mmio_bus_decoder;

    localparam int unsigned NDEV    = 3;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               cpu_req;
    logic               cpu_we;
    logic [AW-1:0]      cpu_addr;
    logic [DW-1:0]      cpu_wdata;
    logic [DW-1:0]      cpu_rdata;
    logic               cpu_ready;
    logic               cpu_err;
    logic [NDEV-1:0]    dev_sel;
    logic               dev_we;
    logic [AW-1:0]      dev_addr;
    logic [DW-1:0]      dev_wdata;
    logic [NDEV*DW-1:0] dev_rdata;
    logic [NDEV-1:0]    dev_ack;

    always #5 clk = ~clk;

    mmio_bus_decoder #(
        .NDEV    (NDEV),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .dev_sel   (dev_sel),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack)
    );

    // Address map as the system documents it: data memory, mouse, sprite memory.
    logic [AW-1:0] m_base [NDEV] = '{32'h0000_0000, 32'h0000_0040, 32'h0000_1000};
    logic [AW-1:0] m_mask [NDEV] = '{32'h0000_003F, 32'h0000_0000, 32'h0000_0FFF};

    typedef struct packed {
        logic [NDEV-1:0] sel;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic            ready;
        logic            err;
        logic [DW-1:0]   rdata;
    } exp_t;

    typedef struct packed {
        int              lat;
        int              sel_cycles;
        logic [NDEV-1:0] first_sel;
        logic [AW-1:0]   first_addr;
        logic [DW-1:0]   rdata;
        logic            err;
    } obs_t;

    exp_t exp_tab [int];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Every-cycle comparison against the expectation table (absent entry = idle).
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            e = exp_tab.exists(cyc) ? exp_tab[cyc] : '0;
            check("dev_sel",   DW'(dev_sel),   DW'(e.sel));
            check("dev_we",    DW'(dev_we),    DW'(e.we));
            check("cpu_ready", DW'(cpu_ready), DW'(e.ready));
            check("cpu_err",   DW'(cpu_err),   DW'(e.err));
            check("cpu_rdata", cpu_rdata,      e.rdata);
            if (e.sel != '0) begin
                check("dev_addr",  DW'(dev_addr), DW'(e.addr));
                check("dev_wdata", dev_wdata,     e.wdata);
            end
        end
    end

    // One core access. wait_n = ACCESS cycles before the ack (<0: never acks);
    // abort_at > 0 asserts reset during that ACCESS cycle.
    task automatic access(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                          input int wait_n, input logic [DW-1:0] ack_data, input int abort_at,
                          output obs_t o);
        int   c0, idx, n_acc, total, abort_k;
        bit   hit, timed_out, has_resp;
        exp_t e;

        o = '0;
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < int'(NDEV); i++) begin
            if (!hit && ((addr & ~m_mask[i]) == m_base[i])) begin
                hit = 1'b1;
                idx = i;
            end
        end

        abort_k   = abort_at;
        timed_out = 1'b0;
        if (!hit) begin
            n_acc = 0;
        end else if (wait_n < 0 || wait_n >= int'(TIMEOUT)) begin
`ifdef MMIO_TIMEOUT_EN
            n_acc     = int'(TIMEOUT);
            timed_out = 1'b1;
`else
            if (abort_k == 0) abort_k = 100;
            n_acc = abort_k;
`endif
        end else begin
            n_acc = wait_n + 1;
        end
        if (abort_k > 0 && abort_k <= n_acc) begin
            n_acc    = abort_k;
            has_resp = 1'b0;
        end else begin
            abort_k  = 0;
            has_resp = 1'b1;
        end

        @(posedge clk); #1;
        c0        = cyc;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        dev_ack   = '0;
        dev_rdata = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        if (hit) dev_rdata[idx*DW +: DW] = ack_data;

        for (int k = 1; k <= n_acc; k++) begin
            e       = '0;
            e.sel   = NDEV'(1) << idx;
            e.we    = we;
            e.addr  = addr & m_mask[idx];
            e.wdata = wdata;
            exp_tab[c0 + k] = e;
        end
        if (has_resp) begin
            e       = '0;
            e.ready = 1'b1;
            e.err   = !hit || timed_out;
            e.rdata = (e.err || we) ? '0 : ack_data;
            exp_tab[c0 + n_acc + 1] = e;
        end

        total = n_acc + (has_resp ? 1 : 0);
        for (int k = 1; k <= total; k++) begin
            @(posedge clk); #1;
            dev_ack = '0;
            if (k <= n_acc) begin
                dev_ack = ~(NDEV'(1) << idx);
                if (k - 1 == wait_n) dev_ack[idx] = 1'b1;
                if (k == abort_k) reset = 1'b1;
            end else begin
                cpu_req = 1'b0;
            end
            if (dev_sel != '0) begin
                if (o.sel_cycles == 0) begin
                    o.first_sel  = dev_sel;
                    o.first_addr = dev_addr;
                end
                o.sel_cycles++;
            end
            if (cpu_ready && o.lat == 0) begin
                o.lat   = k;
                o.rdata = cpu_rdata;
                o.err   = cpu_err;
            end
        end

        if (abort_k > 0) begin
            @(posedge clk); #1;
            reset   = 1'b0;
            cpu_req = 1'b0;
            dev_ack = '0;
            if (cpu_ready) o.lat = n_acc + 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        obs_t o;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dev_rdata = '0;
        dev_ack   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dev_sel",   DW'(dev_sel),   '0);
        check("rst_cpu_ready", DW'(cpu_ready), '0);
        check("rst_cpu_err",   DW'(cpu_err),   '0);
        check("rst_cpu_rdata", cpu_rdata,      '0);
        check("rst_dev_addr",  DW'(dev_addr),  '0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Data memory read, ack in the first ACCESS cycle.
        access(32'h24, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 0, o);
        check("t1_sel",   DW'(o.first_sel),  32'h1);
        check("t1_addr",  DW'(o.first_addr), 32'h24);
        check("t1_lat",   DW'(o.lat),        32'd2);
        check("t1_rdata", o.rdata,           32'hDEAD_BEEF);
        check("t1_err",   DW'(o.err),        32'h0);

        // Mouse write with three wait cycles.
        access(32'h40, 1'b1, 32'h5, 3, 32'hFFFF_0000, 0, o);
        check("t2_sel",    DW'(o.first_sel),  32'h2);
        check("t2_addr",   DW'(o.first_addr), 32'h0);
        check("t2_selcyc", DW'(o.sel_cycles), 32'd4);
        check("t2_lat",    DW'(o.lat),        32'd5);
        check("t2_rdata",  o.rdata,           32'h0);

        // Sprite memory read.
        access(32'h1234, 1'b0, 32'h0, 1, 32'h77, 0, o);
        check("t3_sel",   DW'(o.first_sel),  32'h4);
        check("t3_addr",  DW'(o.first_addr), 32'h234);
        check("t3_rdata", o.rdata,           32'h77);

        // Unmapped read, then unmapped just past the sprite window.
        access(32'h44, 1'b0, 32'h0, 0, 32'h1111_1111, 0, o);
        check("t4_selcyc", DW'(o.sel_cycles), 32'd0);
        check("t4_lat",    DW'(o.lat),        32'd1);
        check("t4_err",    DW'(o.err),        32'h1);
        check("t4_rdata",  o.rdata,           32'h0);
        access(32'h2000, 1'b1, 32'h9, 0, 32'h0, 0, o);
        check("t4b_err", DW'(o.err), 32'h1);

        // Region edges: top of data memory (ack in last allowed cycle), top of sprite.
        access(32'h3F, 1'b0, 32'h0, int'(TIMEOUT) - 1, 32'hCAFE_0001, 0, o);
        check("t5_lat",   DW'(o.lat), 32'(TIMEOUT + 1));
        check("t5_err",   DW'(o.err), 32'h0);
        access(32'h1FFF, 1'b1, 32'hABCD, 2, 32'h0, 0, o);
        check("t5b_addr", DW'(o.first_addr), 32'hFFF);

        // Target never acks.
        access(32'h0, 1'b0, 32'h0, -1, 32'h0, 0, o);
`ifdef MMIO_TIMEOUT_EN
        check("t6_selcyc", DW'(o.sel_cycles), 32'(TIMEOUT));
        check("t6_lat",    DW'(o.lat),        32'(TIMEOUT + 1));
        check("t6_err",    DW'(o.err),        32'h1);
`else
        check("t6_selcyc", DW'(o.sel_cycles), 32'd100);
        check("t6_lat",    DW'(o.lat),        32'd0);
`endif

        // Reset in the second ACCESS cycle, then a normal read.
        access(32'h0, 1'b0, 32'h0, -1, 32'h0, 2, o);
        check("t7_selcyc", DW'(o.sel_cycles), 32'd2);
        check("t7_lat",    DW'(o.lat),        32'd0);
        access(32'h0, 1'b0, 32'h0, 0, 32'h1234_5678, 0, o);
        check("t7b_lat",   DW'(o.lat),   32'd2);
        check("t7b_rdata", o.rdata,      32'h1234_5678);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
